// File: rtl/spi_bist_pkg.sv
// Shared definitions for the spi_phy BIST engine: FSM states, failure codes
// and the per-width LFSR feedback tap masks.
package spi_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_W_IDLE = 4'd1,
    ST_WRITE  = 4'd2,
    ST_W_BSY  = 4'd3,
    ST_W_RDY  = 4'd4,
    ST_READ   = 4'd5,
    ST_CHECK  = 4'd6,
    ST_DONE   = 4'd7,
    ST_FAIL   = 4'd8
  } state_e;

  localparam logic [1:0] FAIL_NONE = 2'd0;
  localparam logic [1:0] FAIL_DATA = 2'd1;
  localparam logic [1:0] FAIL_BSY  = 2'd2;
  localparam logic [1:0] FAIL_RDY  = 2'd3;

  // Tap positions (bit set = tap) XOR-ed into the new bit0
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_D008;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci shift-left LFSR producing the BIST word sequence; load restores SEED,
// step advances one position.
module lfsr_gen
  import spi_bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h9B)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_value
);

  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] value_r;
  logic             feedback_s;

  assign feedback_s = ^(value_r & TAPS);
  assign o_value    = value_r;

  // LFSR state register: load has priority over step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_r <= SEED;
    end else if (i_load) begin
      value_r <= SEED;
    end else if (i_step) begin
      value_r <= {value_r[WIDTH-2:0], feedback_s};
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/spi_phy_bist.sv
// BIST engine for spi_phy: writes COUNT LFSR words through the parallel handshake
// and checks each looped-back word, reporting the first failure.
module spi_phy_bist
  import spi_bist_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               COUNT   = 16,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h9B),
  parameter bit               INVERT  = 1'b1,
  parameter int               TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  output logic             o_running,
  output logic             o_done,
  output logic             o_passed,
  output logic [1:0]       o_fail_code,
  output logic [7:0]       o_fail_idx,
  output logic [WIDTH-1:0] o_fail_data,
  output logic             o_wr,
  output logic [WIDTH-1:0] o_wdata,
  input  logic             i_bsy,
  input  logic             i_rdy,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_rd
);

  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);
  localparam logic [8:0] TMO_LAST = 9'(TIMEOUT - 1);

  state_e           state_r, state_next_s;
  logic [8:0]       timer_r;
  logic [7:0]       idx_r;
  logic [WIDTH-1:0] exp_r, rdata_r, lfsr_s;
  logic             timeout_s, start_s, fail_enter_s, lfsr_step_s;
  logic [1:0]       fail_cause_s;

  logic             running_r, done_r, passed_r, wr_r, rd_r;
  logic [1:0]       fail_code_r;
  logic [7:0]       fail_idx_r;
  logic [WIDTH-1:0] fail_data_r, wdata_r;
  logic             running_next_s, done_next_s, passed_next_s, wr_next_s, rd_next_s;
  logic [1:0]       fail_code_next_s;
  logic [7:0]       fail_idx_next_s;
  logic [WIDTH-1:0] fail_data_next_s, wdata_next_s;

  lfsr_gen #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (start_s),
    .i_step  (lfsr_step_s),
    .o_value (lfsr_s)
  );

  assign timeout_s = (timer_r == TMO_LAST);

  // State, datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      timer_r     <= 9'd0;
      idx_r       <= 8'd0;
      exp_r       <= '0;
      rdata_r     <= '0;
      running_r   <= 1'b0;
      done_r      <= 1'b0;
      passed_r    <= 1'b1;
      fail_code_r <= FAIL_NONE;
      fail_idx_r  <= 8'd0;
      fail_data_r <= '0;
      wr_r        <= 1'b0;
      wdata_r     <= '0;
      rd_r        <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      timer_r     <= (state_next_s != state_r) ? 9'd0 :
                     ((state_r == ST_W_IDLE) || (state_r == ST_W_BSY) || (state_r == ST_W_RDY))
                       ? timer_r + 9'd1 : timer_r;
      idx_r       <= start_s ? 8'd0 : (lfsr_step_s ? idx_r + 8'd1 : idx_r);
      exp_r       <= (state_next_s == ST_WRITE) ? (INVERT ? ~lfsr_s : lfsr_s) : exp_r;
      rdata_r     <= (state_r == ST_READ) ? i_rdata : rdata_r;
      running_r   <= running_next_s;
      done_r      <= done_next_s;
      passed_r    <= passed_next_s;
      fail_code_r <= fail_code_next_s;
      fail_idx_r  <= fail_idx_next_s;
      fail_data_r <= fail_data_next_s;
      wr_r        <= wr_next_s;
      wdata_r     <= wdata_next_s;
      rd_r        <= rd_next_s;
    end
  end

  // Next-state logic; a low i_run aborts any running state
  always_comb begin
    state_next_s = state_r;
    fail_cause_s = FAIL_NONE;
    case (state_r)
      ST_IDLE: begin
        if (i_run) state_next_s = ST_W_IDLE;
        else       state_next_s = ST_IDLE;
      end
      ST_W_IDLE: begin
        if (!i_run)         state_next_s = ST_IDLE;
        else if (!i_bsy)    state_next_s = ST_WRITE;
        else if (timeout_s) begin
          state_next_s = ST_FAIL;
          fail_cause_s = FAIL_BSY;
        end else            state_next_s = ST_W_IDLE;
      end
      ST_WRITE: begin
        if (!i_run) state_next_s = ST_IDLE;
        else        state_next_s = ST_W_BSY;
      end
      ST_W_BSY: begin
        if (!i_run)         state_next_s = ST_IDLE;
        else if (i_bsy)     state_next_s = ST_W_RDY;
        else if (timeout_s) begin
          state_next_s = ST_FAIL;
          fail_cause_s = FAIL_BSY;
        end else            state_next_s = ST_W_BSY;
      end
      ST_W_RDY: begin
        if (!i_run)         state_next_s = ST_IDLE;
        else if (i_rdy)     state_next_s = ST_READ;
        else if (timeout_s) begin
          state_next_s = ST_FAIL;
          fail_cause_s = FAIL_RDY;
        end else            state_next_s = ST_W_RDY;
      end
      ST_READ: begin
        if (!i_run) state_next_s = ST_IDLE;
        else        state_next_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (!i_run)                   state_next_s = ST_IDLE;
        else if (rdata_r != exp_r) begin
          state_next_s = ST_FAIL;
          fail_cause_s = FAIL_DATA;
        end else if (idx_r == LAST_IDX) state_next_s = ST_DONE;
        else                          state_next_s = ST_W_IDLE;
      end
      ST_DONE, ST_FAIL: begin
        if (!i_run) state_next_s = ST_IDLE;
        else        state_next_s = state_r;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    start_s          = (state_r == ST_IDLE) && (state_next_s == ST_W_IDLE);
    fail_enter_s     = (state_next_s == ST_FAIL) && (state_r != ST_FAIL);
    lfsr_step_s      = (state_r == ST_CHECK) && (state_next_s == ST_W_IDLE);
    running_next_s   = (state_next_s != ST_IDLE) && (state_next_s != ST_DONE) &&
                       (state_next_s != ST_FAIL);
    done_next_s      = (state_next_s == ST_DONE) || (state_next_s == ST_FAIL);
    wr_next_s        = (state_next_s == ST_WRITE);
    rd_next_s        = (state_next_s == ST_READ);
    wdata_next_s     = (state_next_s == ST_WRITE) ? lfsr_s : wdata_r;
    passed_next_s    = passed_r;
    fail_code_next_s = fail_code_r;
    fail_idx_next_s  = fail_idx_r;
    fail_data_next_s = fail_data_r;
    if (start_s) begin
      passed_next_s    = 1'b1;
      fail_code_next_s = FAIL_NONE;
      fail_idx_next_s  = 8'd0;
      fail_data_next_s = '0;
    end else if (fail_enter_s) begin
      passed_next_s    = 1'b0;
      fail_code_next_s = fail_cause_s;
      fail_idx_next_s  = idx_r;
      fail_data_next_s = (fail_cause_s == FAIL_DATA) ? rdata_r : '0;
    end else begin
      passed_next_s    = passed_r;
    end
  end

  assign o_running   = running_r;
  assign o_done      = done_r;
  assign o_passed    = passed_r;
  assign o_fail_code = fail_code_r;
  assign o_fail_idx  = fail_idx_r;
  assign o_fail_data = fail_data_r;
  assign o_wr        = wr_r;
  assign o_wdata     = wdata_r;
  assign o_rd        = rd_r;

endmodule

// File: tb/tb_spi_phy_bist.sv
// Directed bench for spi_phy_bist: behavioural spi_phy loopback models around an
// 8-bit and a 16-bit engine, checked with immediate assertions.
module tb_spi_phy_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run8, run16;
  logic loop_inv, corrupt, rdy_stuck;
  int checks = 0;
  int errors = 0;

  logic        running8, done8, passed8, wr8, rd8, bsy8, rdy8;
  logic [1:0]  code8;
  logic [7:0]  fidx8, fdata8, wdata8, rdata8;
  logic        running16, done16, passed16, wr16, rd16, bsy16, rdy16;
  logic [1:0]  code16;
  logic [7:0]  fidx16;
  logic [15:0] fdata16, wdata16, rdata16;

  spi_phy_bist #(.WIDTH(8), .COUNT(4), .SEED(8'h9B), .INVERT(1'b1), .TIMEOUT(20)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_run(run8), .o_running(running8), .o_done(done8),
    .o_passed(passed8), .o_fail_code(code8), .o_fail_idx(fidx8), .o_fail_data(fdata8),
    .o_wr(wr8), .o_wdata(wdata8), .i_bsy(bsy8), .i_rdy(rdy8), .i_rdata(rdata8), .o_rd(rd8)
  );

  spi_phy_bist #(.WIDTH(16), .COUNT(8), .SEED(16'h009B), .INVERT(1'b1), .TIMEOUT(255)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_run(run16), .o_running(running16), .o_done(done16),
    .o_passed(passed16), .o_fail_code(code16), .o_fail_idx(fidx16), .o_fail_data(fdata16),
    .o_wr(wr16), .o_wdata(wdata16), .i_bsy(bsy16), .i_rdy(rdy16), .i_rdata(rdata16), .o_rd(rd16)
  );

  // 8-bit phy model: busy for 3 cycles after a write, then rdy with looped data
  int bcnt8 = 0;
  always @(posedge clk) begin
    if (rst) begin
      bsy8 <= 1'b0; rdy8 <= 1'b0; rdata8 <= 8'h00; bcnt8 <= 0;
    end else begin
      if (wr8) begin
        bsy8   <= 1'b1;
        rdy8   <= 1'b0;
        bcnt8  <= 3;
        rdata8 <= (loop_inv ? ~wdata8 : wdata8) ^ ((corrupt && wdata8 == 8'h6E) ? 8'h01 : 8'h00);
      end else if (bcnt8 > 0) begin
        bcnt8 <= bcnt8 - 1;
        if (bcnt8 == 1) begin
          bsy8 <= 1'b0;
          rdy8 <= !rdy_stuck;
        end
      end
      if (rd8) rdy8 <= 1'b0;
    end
  end

  int bcnt16 = 0;
  always @(posedge clk) begin
    if (rst) begin
      bsy16 <= 1'b0; rdy16 <= 1'b0; rdata16 <= 16'h0000; bcnt16 <= 0;
    end else begin
      if (wr16) begin
        bsy16 <= 1'b1; rdy16 <= 1'b0; bcnt16 <= 2; rdata16 <= ~wdata16;
      end else if (bcnt16 > 0) begin
        bcnt16 <= bcnt16 - 1;
        if (bcnt16 == 1) begin
          bsy16 <= 1'b0;
          rdy16 <= 1'b1;
        end
      end
      if (rd16) rdy16 <= 1'b0;
    end
  end

  // Write-strobe monitors: count strobe cycles and log the data written
  int          wr8_cnt = 0;
  int          wr16_cnt = 0;
  logic [7:0]  wlog8 [64];
  logic [15:0] wlog16 [64];
  always @(posedge clk) begin
    if (wr8) begin
      wlog8[wr8_cnt % 64] <= wdata8;
      wr8_cnt <= wr8_cnt + 1;
    end
    if (wr16) begin
      wlog16[wr16_cnt % 64] <= wdata16;
      wr16_cnt <= wr16_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done8(input string tag, input int max, output int n);
    n = 0;
    while (!done8 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bounded"}, {31'd0, done8}, 32'd1);
  endtask

  task automatic wait_wr8(input string tag, input int max);
    int n = 0;
    while (!wr8 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr_seen"}, {31'd0, wr8}, 32'd1);
  endtask

  task automatic check_reset8(input string tag);
    chk({tag, "_running"}, {31'd0, running8}, 32'd0);
    chk({tag, "_done"},    {31'd0, done8},    32'd0);
    chk({tag, "_passed"},  {31'd0, passed8},  32'd1);
    chk({tag, "_code"},    {30'd0, code8},    32'd0);
    chk({tag, "_idx"},     {24'd0, fidx8},    32'd0);
    chk({tag, "_data"},    {24'd0, fdata8},   32'd0);
    chk({tag, "_wr"},      {31'd0, wr8},      32'd0);
    chk({tag, "_wdata"},   {24'd0, wdata8},   32'd0);
    chk({tag, "_rd"},      {31'd0, rd8},      32'd0);
  endtask

  logic [7:0]  exp_seq8  [4] = '{8'h9B, 8'h37, 8'h6E, 8'hDC};
  logic [15:0] exp_seq16 [4] = '{16'h009B, 16'h0137, 16'h026E, 16'h04DD};
  int base, n;

  initial begin
    rst = 1'b1; run8 = 1'b0; run16 = 1'b0;
    loop_inv = 1'b1; corrupt = 1'b0; rdy_stuck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset8("reset");

    // Inverted loopback: clean pass with the known word sequence
    base = wr8_cnt;
    run8 = 1'b1;
    wait_done8("pass", 200, n);
    chk("pass_passed", {31'd0, passed8}, 32'd1);
    chk("pass_code", {30'd0, code8}, 32'd0);
    chk("pass_running", {31'd0, running8}, 32'd0);
    chk("pass_wr_count", wr8_cnt - base, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("pass_wdata%0d", i), {24'd0, wlog8[(base + i) % 64]}, {24'd0, exp_seq8[i]});
    run8 = 1'b0;
    @(negedge clk);
    chk("pass_rearm_done", {31'd0, done8}, 32'd0);

    // Straight loopback against an inverting expectation: fails on word 0
    loop_inv = 1'b0;
    @(negedge clk);
    run8 = 1'b1;
    wait_done8("noinv", 200, n);
    chk("noinv_passed", {31'd0, passed8}, 32'd0);
    chk("noinv_code", {30'd0, code8}, 32'd1);
    chk("noinv_idx", {24'd0, fidx8}, 32'd0);
    chk("noinv_data", {24'd0, fdata8}, 32'h9B);
    run8 = 1'b0;
    @(negedge clk);
    chk("noinv_hold_code", {30'd0, code8}, 32'd1);
    chk("noinv_hold_done", {31'd0, done8}, 32'd0);

    // Bit 0 flipped on word 2 only
    loop_inv = 1'b1; corrupt = 1'b1;
    @(negedge clk);
    run8 = 1'b1;
    wait_done8("corrupt", 200, n);
    chk("corrupt_code", {30'd0, code8}, 32'd1);
    chk("corrupt_idx", {24'd0, fidx8}, 32'd2);
    chk("corrupt_data", {24'd0, fdata8}, 32'h90);
    chk("corrupt_passed", {31'd0, passed8}, 32'd0);
    run8 = 1'b0; corrupt = 1'b0;
    @(negedge clk);

    // rdy never rises: ready timeout after 20 cycles in W_RDY
    rdy_stuck = 1'b1;
    @(negedge clk);
    run8 = 1'b1;
    wait_done8("rdytmo", 100, n);
    chk("rdytmo_latency", n, 32'd24);
    chk("rdytmo_code", {30'd0, code8}, 32'd3);
    chk("rdytmo_data", {24'd0, fdata8}, 32'd0);
    chk("rdytmo_idx", {24'd0, fidx8}, 32'd0);
    run8 = 1'b0; rdy_stuck = 1'b0;
    @(negedge clk);

    // Abort while waiting in W_BSY, then restart from the seed
    run8 = 1'b1;
    wait_wr8("abort", 20);
    @(negedge clk);
    run8 = 1'b0;
    @(negedge clk);
    chk("abort_running", {31'd0, running8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_wr", {31'd0, wr8}, 32'd0);
    chk("abort_rd", {31'd0, rd8}, 32'd0);
    repeat (8) @(negedge clk);
    run8 = 1'b1;
    wait_wr8("rerun", 20);
    chk("rerun_wdata", {24'd0, wdata8}, 32'h9B);
    wait_done8("rerun", 200, n);
    chk("rerun_passed", {31'd0, passed8}, 32'd1);
    run8 = 1'b0;
    @(negedge clk);

    // Reset pulsed while parked in W_RDY, then a full passing run
    rdy_stuck = 1'b1;
    run8 = 1'b1;
    wait_wr8("rstmid", 20);
    repeat (5) @(negedge clk);
    chk("rstmid_running", {31'd0, running8}, 32'd1);
    rst = 1'b1; run8 = 1'b0;
    @(negedge clk);
    check_reset8("rstmid");
    rst = 1'b0; rdy_stuck = 1'b0;
    @(negedge clk);
    run8 = 1'b1;
    wait_done8("postrst", 200, n);
    chk("postrst_passed", {31'd0, passed8}, 32'd1);
    chk("postrst_code", {30'd0, code8}, 32'd0);
    run8 = 1'b0;
    @(negedge clk);

    // 16-bit engine, eight words
    base = wr16_cnt;
    run16 = 1'b1;
    n = 0;
    while (!done16 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("w16_done", {31'd0, done16}, 32'd1);
    chk("w16_passed", {31'd0, passed16}, 32'd1);
    chk("w16_code", {30'd0, code16}, 32'd0);
    chk("w16_wr_count", wr16_cnt - base, 32'd8);
    for (int i = 0; i < 4; i++) chk($sformatf("w16_wdata%0d", i), {16'd0, wlog16[(base + i) % 64]}, {16'd0, exp_seq16[i]});
    run16 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
